// File: rtl/regfile_dbg_arbiter.sv
// Arbitrates the integer register file's write port and rs1 read port between
// the pipeline and a debug host; halts and drains the core before debug accesses.
module regfile_dbg_arbiter #(
    parameter int unsigned DRAIN_CYCLES = 3
) (
    input  logic        sys_clk_i,
    input  logic        rst_i,
    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [4:0]  dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    input  logic        dbg_hold_i,
    output logic        dbg_ack_o,
    output logic [31:0] dbg_rdata_o,
    output logic        halt_o,
    output logic        halted_o,
    input  logic [4:0]  id_rs1_raddr_i,
    output logic [4:0]  rf_rs1_raddr_o,
    input  logic [31:0] rf_rs1_rdata_i,
    input  logic        wb_wr_en_i,
    input  logic [4:0]  wb_waddr_i,
    input  logic [31:0] wb_wdata_i,
    output logic        rf_wr_en_o,
    output logic [4:0]  rf_waddr_o,
    output logic [31:0] rf_wdata_o
);

    typedef enum logic [2:0] {
        ST_RUN,
        ST_DRAIN,
        ST_ACCESS,
        ST_RESP,
        ST_HALTED
    } state_e;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  drainCnt_q, drainCnt_d;
    logic        reqWe_q, reqWe_d;
    logic [4:0]  reqAddr_q, reqAddr_d;
    logic [31:0] reqWdata_q, reqWdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        accept;

    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            state_q    <= ST_RUN;
            drainCnt_q <= 4'd0;
            reqWe_q    <= 1'b0;
            reqAddr_q  <= 5'd0;
            reqWdata_q <= 32'd0;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            drainCnt_q <= drainCnt_d;
            reqWe_q    <= reqWe_d;
            reqAddr_q  <= reqAddr_d;
            reqWdata_q <= reqWdata_d;
            rdata_q    <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        drainCnt_d = drainCnt_q;
        reqWe_d    = reqWe_q;
        reqAddr_d  = reqAddr_q;
        reqWdata_d = reqWdata_q;
        rdata_d    = rdata_q;
        accept     = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (dbg_req_i) begin
                    accept     = 1'b1;
                    drainCnt_d = DRAIN_LOAD;
                    state_d    = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drainCnt_q <= 4'd1) begin
                    state_d = ST_ACCESS;
                end else begin
                    drainCnt_d = drainCnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                // A writeback in flight owns the port; retry the debug access next cycle.
                if (!wb_wr_en_i) begin
                    state_d = ST_RESP;
                    if (!reqWe_q) begin
                        rdata_d = (reqAddr_q == 5'd0) ? 32'd0 : rf_rs1_rdata_i;
                    end
                end
            end
            ST_RESP: begin
                state_d = dbg_hold_i ? ST_HALTED : ST_RUN;
            end
            ST_HALTED: begin
                if (dbg_req_i) begin
                    accept  = 1'b1;
                    state_d = ST_ACCESS;
                end else if (!dbg_hold_i) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        if (accept) begin
            reqWe_d    = dbg_we_i;
            reqAddr_d  = dbg_addr_i;
            reqWdata_d = dbg_wdata_i;
        end
    end

    always_comb begin
        rf_wr_en_o     = wb_wr_en_i;
        rf_waddr_o     = wb_waddr_i;
        rf_wdata_o     = wb_wdata_i;
        rf_rs1_raddr_o = id_rs1_raddr_i;

        if (state_q == ST_ACCESS) begin
            if (!reqWe_q) begin
                rf_rs1_raddr_o = reqAddr_q;
            end else if (!wb_wr_en_i) begin
                // x0 is hardwired, so a debug write to it completes without touching the port.
                rf_wr_en_o = (reqAddr_q != 5'd0);
                rf_waddr_o = reqAddr_q;
                rf_wdata_o = reqWdata_q;
            end
        end
    end

    assign dbg_ack_o   = (state_q == ST_RESP);
    assign dbg_rdata_o = rdata_q;
    assign halt_o      = (state_q != ST_RUN);
    assign halted_o    = (state_q == ST_ACCESS) || (state_q == ST_RESP) || (state_q == ST_HALTED);

endmodule

// File: tb/tb_regfile_dbg_arbiter.sv
// Self-checking bench for regfile_dbg_arbiter with a behavioural register file
// attached to its ports; directed vector table plus multi-cycle sequences.
module tb_regfile_dbg_arbiter;

    logic        sys_clk_i = 1'b0;
    logic        rst_i;
    logic        dbg_req_i, dbg_we_i, dbg_hold_i;
    logic [4:0]  dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_ack_o, halt_o, halted_o;
    logic [31:0] dbg_rdata_o;
    logic [4:0]  id_rs1_raddr_i, rf_rs1_raddr_o;
    logic [31:0] rf_rs1_rdata_i;
    logic        wb_wr_en_i, rf_wr_en_o;
    logic [4:0]  wb_waddr_i, rf_waddr_o;
    logic [31:0] wb_wdata_i, rf_wdata_o;

    logic [31:0] regs [32];
    logic        rfInit;

    int checks = 0;
    int errors = 0;

    regfile_dbg_arbiter #(.DRAIN_CYCLES(3)) dut (
        .sys_clk_i      (sys_clk_i),
        .rst_i          (rst_i),
        .dbg_req_i      (dbg_req_i),
        .dbg_we_i       (dbg_we_i),
        .dbg_addr_i     (dbg_addr_i),
        .dbg_wdata_i    (dbg_wdata_i),
        .dbg_hold_i     (dbg_hold_i),
        .dbg_ack_o      (dbg_ack_o),
        .dbg_rdata_o    (dbg_rdata_o),
        .halt_o         (halt_o),
        .halted_o       (halted_o),
        .id_rs1_raddr_i (id_rs1_raddr_i),
        .rf_rs1_raddr_o (rf_rs1_raddr_o),
        .rf_rs1_rdata_i (rf_rs1_rdata_i),
        .wb_wr_en_i     (wb_wr_en_i),
        .wb_waddr_i     (wb_waddr_i),
        .wb_wdata_i     (wb_wdata_i),
        .rf_wr_en_o     (rf_wr_en_o),
        .rf_waddr_o     (rf_waddr_o),
        .rf_wdata_o     (rf_wdata_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    // Register file model: x0 deliberately holds garbage so the arbiter must force zero itself.
    always @(posedge sys_clk_i) begin
        if (rfInit) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'hBAD0_0000 | 32'(i);
        end else if (rf_wr_en_o) begin
            regs[rf_waddr_o] <= rf_wdata_o;
        end
    end
    assign rf_rs1_rdata_i = regs[rf_rs1_raddr_o];

    typedef struct {
        logic        req;
        logic        we;
        logic [4:0]  addr;
        logic [31:0] wdata;
        logic        hold;
        logic        wbEn;
        logic [4:0]  wbAddr;
        logic [31:0] wbData;
        logic [4:0]  idAddr;
        logic        expAck;
        logic        expHalt;
        logic        expHalted;
        logic        expWrEn;
        logic [4:0]  expWaddr;
        logic [31:0] expWdata;
        logic [4:0]  expRs1;
    } vec_t;

    vec_t vecs [9];

    task automatic applyStimulus(input vec_t v);
        dbg_req_i      = v.req;
        dbg_we_i       = v.we;
        dbg_addr_i     = v.addr;
        dbg_wdata_i    = v.wdata;
        dbg_hold_i     = v.hold;
        wb_wr_en_i     = v.wbEn;
        wb_waddr_i     = v.wbAddr;
        wb_wdata_i     = v.wbData;
        id_rs1_raddr_i = v.idAddr;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Called in the acceptance cycle; drops req after it and counts cycles to ack.
    task automatic waitAck(input int maxCycles, output int cycles, output logic sawWr, output logic gotAck);
        cycles = 0;
        sawWr  = 1'b0;
        gotAck = 1'b0;
        while (cycles < maxCycles && !gotAck) begin
            @(negedge sys_clk_i);
            dbg_req_i = 1'b0;
            cycles++;
            #1;
            if (rf_wr_en_o) sawWr = 1'b1;
            if (dbg_ack_o) gotAck = 1'b1;
        end
    endtask

    task automatic idleInputs();
        dbg_req_i      = 1'b0;
        dbg_we_i       = 1'b0;
        dbg_addr_i     = 5'd0;
        dbg_wdata_i    = 32'd0;
        dbg_hold_i     = 1'b0;
        wb_wr_en_i     = 1'b0;
        wb_waddr_i     = 5'd0;
        wb_wdata_i     = 32'd0;
        id_rs1_raddr_i = 5'd0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation timeout");
    end

    initial begin
        int   lat;
        logic sawWr, gotAck, anyAck, anyWr;

        // Cold write to x5, then WB passthrough back in RUN.
        vecs[0] = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0, 32'd0, 5'd2,
                    1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd2};
        vecs[1] = '{1'b0, 1'b0, 5'd9, 32'h11111111, 1'b0, 1'b0, 5'd0, 32'd0, 5'd4,
                    1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd4};
        vecs[2] = '{1'b0, 1'b0, 5'd9, 32'h11111111, 1'b0, 1'b0, 5'd0, 32'd0, 5'd4,
                    1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd4};
        vecs[3] = '{1'b0, 1'b0, 5'd9, 32'h11111111, 1'b0, 1'b0, 5'd0, 32'd0, 5'd4,
                    1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd4};
        vecs[4] = '{1'b0, 1'b0, 5'd9, 32'h11111111, 1'b0, 1'b0, 5'd0, 32'd0, 5'd4,
                    1'b0, 1'b1, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd4};
        vecs[5] = '{1'b0, 1'b0, 5'd9, 32'h11111111, 1'b0, 1'b0, 5'd0, 32'd0, 5'd4,
                    1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0, 5'd4};
        vecs[6] = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd3, 32'h000000A5, 5'd6,
                    1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h000000A5, 5'd6};
        vecs[7] = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 5'd8, 32'hCAFE0001, 5'd1,
                    1'b0, 1'b0, 1'b0, 1'b1, 5'd8, 32'hCAFE0001, 5'd1};
        vecs[8] = '{1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0,
                    1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0};

        // Reset: outputs quiet, WB write port still passes through.
        idleInputs();
        rst_i      = 1'b1;
        rfInit     = 1'b1;
        wb_wr_en_i = 1'b1;
        wb_waddr_i = 5'd12;
        repeat (2) @(negedge sys_clk_i);
        #1;
        checkOutput("reset.ack", dbg_ack_o, 0);
        checkOutput("reset.rdata", dbg_rdata_o, 0);
        checkOutput("reset.halt", halt_o, 0);
        checkOutput("reset.halted", halted_o, 0);
        checkOutput("reset.wrEnPass", rf_wr_en_o, 1);
        @(negedge sys_clk_i);
        rst_i  = 1'b0;
        rfInit = 1'b0;
        idleInputs();

        for (int i = 0; i < 9; i++) begin
            @(negedge sys_clk_i);
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("row%0d.ack", i), dbg_ack_o, vecs[i].expAck);
            checkOutput($sformatf("row%0d.halt", i), halt_o, vecs[i].expHalt);
            checkOutput($sformatf("row%0d.halted", i), halted_o, vecs[i].expHalted);
            checkOutput($sformatf("row%0d.wrEn", i), rf_wr_en_o, vecs[i].expWrEn);
            checkOutput($sformatf("row%0d.waddr", i), rf_waddr_o, vecs[i].expWaddr);
            checkOutput($sformatf("row%0d.wdata", i), rf_wdata_o, vecs[i].expWdata);
            checkOutput($sformatf("row%0d.rs1", i), rf_rs1_raddr_o, vecs[i].expRs1);
        end
        checkOutput("cold.x5", regs[5], 32'hDEADBEEF);
        idleInputs();

        // Held multi-access: write x7 then read it back without a second drain.
        @(negedge sys_clk_i);
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd7; dbg_wdata_i = 32'h1234; dbg_hold_i = 1'b1;
        waitAck(20, lat, sawWr, gotAck);
        checkOutput("held.wrAck", gotAck, 1);
        checkOutput("held.wrLatency", lat, 5);
        @(negedge sys_clk_i);
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd7;
        #1;
        checkOutput("held.haltedBetween", halted_o, 1);
        waitAck(20, lat, sawWr, gotAck);
        checkOutput("held.rdAck", gotAck, 1);
        checkOutput("held.rdLatency", lat, 2);
        checkOutput("held.rdata", dbg_rdata_o, 32'h00001234);
        @(negedge sys_clk_i);
        dbg_hold_i = 1'b0;
        #1;
        checkOutput("held.stillHalted", halted_o, 1);
        @(negedge sys_clk_i);
        #1;
        checkOutput("held.resumeHalt", halt_o, 0);
        checkOutput("held.rdataHolds", dbg_rdata_o, 32'h00001234);

        // x0: write is suppressed on the port, read returns zero.
        @(negedge sys_clk_i);
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd0; dbg_wdata_i = 32'hFFFFFFFF;
        waitAck(20, lat, sawWr, gotAck);
        checkOutput("x0.wrAck", gotAck, 1);
        checkOutput("x0.noWrEn", sawWr, 0);
        @(negedge sys_clk_i);
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 5'd0;
        waitAck(20, lat, sawWr, gotAck);
        checkOutput("x0.rdAck", gotAck, 1);
        checkOutput("x0.rdata", dbg_rdata_o, 0);

        // WB collision during the first two ACCESS cycles of a debug write to x3.
        @(negedge sys_clk_i);
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd3; dbg_wdata_i = 32'h5A;
        for (int c = 1; c <= 3; c++) begin
            @(negedge sys_clk_i);
            dbg_req_i = 1'b0;
            #1;
            checkOutput($sformatf("coll.drain%0d.halt", c), halt_o, 1);
        end
        for (int c = 4; c <= 5; c++) begin
            @(negedge sys_clk_i);
            wb_wr_en_i = 1'b1; wb_waddr_i = 5'd3; wb_wdata_i = 32'hA5;
            #1;
            checkOutput($sformatf("coll.c%0d.halted", c), halted_o, 1);
            checkOutput($sformatf("coll.c%0d.wbData", c), rf_wdata_o, 32'hA5);
            checkOutput($sformatf("coll.c%0d.noAck", c), dbg_ack_o, 0);
        end
        @(negedge sys_clk_i);
        wb_wr_en_i = 1'b0;
        #1;
        checkOutput("coll.dbgWrEn", rf_wr_en_o, 1);
        checkOutput("coll.dbgWaddr", rf_waddr_o, 3);
        checkOutput("coll.dbgWdata", rf_wdata_o, 32'h5A);
        @(negedge sys_clk_i);
        #1;
        checkOutput("coll.ack", dbg_ack_o, 1);
        checkOutput("coll.x3", regs[3], 32'h5A);

        // Reset during the second drain cycle discards the access.
        @(negedge sys_clk_i);
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 5'd9; dbg_wdata_i = 32'h77;
        @(negedge sys_clk_i);
        dbg_req_i = 1'b0;
        @(negedge sys_clk_i);
        rst_i = 1'b1;
        @(negedge sys_clk_i);
        rst_i = 1'b0;
        #1;
        checkOutput("rstDrain.halt", halt_o, 0);
        checkOutput("rstDrain.halted", halted_o, 0);
        checkOutput("rstDrain.rdata", dbg_rdata_o, 0);
        anyAck = dbg_ack_o;
        anyWr  = rf_wr_en_o;
        repeat (10) begin
            @(negedge sys_clk_i);
            #1;
            if (dbg_ack_o) anyAck = 1'b1;
            if (rf_wr_en_o) anyWr = 1'b1;
        end
        checkOutput("rstDrain.noAck", anyAck, 0);
        checkOutput("rstDrain.noWr", anyWr, 0);
        checkOutput("rstDrain.x9", regs[9], 32'hBAD00009);

        // Random passthrough traffic in RUN.
        for (int i = 0; i < 16; i++) begin
            @(negedge sys_clk_i);
            id_rs1_raddr_i = 5'($urandom_range(0, 31));
            wb_wr_en_i     = 1'($urandom_range(0, 1));
            wb_waddr_i     = 5'($urandom_range(1, 31));
            wb_wdata_i     = $urandom;
            #1;
            checkOutput($sformatf("pass%0d.wrEn", i), rf_wr_en_o, wb_wr_en_i);
            checkOutput($sformatf("pass%0d.waddr", i), rf_waddr_o, wb_waddr_i);
            checkOutput($sformatf("pass%0d.wdata", i), rf_wdata_o, wb_wdata_i);
            checkOutput($sformatf("pass%0d.rs1", i), rf_rs1_raddr_o, id_rs1_raddr_i);
            checkOutput($sformatf("pass%0d.ack", i), dbg_ack_o, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_dbg_arbiter.md
# regfile_dbg_arbiter

- Shares the integer register file's write port and rs1 read port between the pipeline (decode reads, writeback writes) and a debug host.
- On a debug request it halts fetch/decode through the hazard path and waits a fixed drain period so in-flight instructions retire.
- It then performs one register read or write and acknowledges.
- It either resumes the core or holds it halted for further accesses.

## Interface

Parameters:
- DRAIN_CYCLES, 3, cycles halt_o is held before the first access so in-flight instructions reach WB; legal range 1..15.

Ports:
- sys_clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- dbg_req_i  in  1  debug access request, level.
- dbg_we_i  in  1  1 = write, 0 = read; sampled when the request is accepted.
- dbg_addr_i  in  5  register index.
- dbg_wdata_i  in  32  write data.
- dbg_hold_i  in  1  keep the core halted after the access completes.
- dbg_ack_o  out  1  one-cycle completion pulse.
- dbg_rdata_o  out  32  read result; valid when dbg_ack_o=1; holds its value until the next ack.
- halt_o  out  1  to hazard_detection_unit; stalls fetch/decode.
- halted_o  out  1  core drained; debug owns the register ports.
- id_rs1_raddr_i  in  5  decode rs1 address.
- rf_rs1_raddr_o  out  5  to regfile rs1 port.
- rf_rs1_rdata_i  in  32  from regfile rs1 port (combinational read).
- wb_wr_en_i, wb_waddr_i[4:0], wb_wdata_i[31:0]  in  writeback write request.
- rf_wr_en_o, rf_waddr_o[4:0], rf_wdata_o[31:0]  out  to regfile write port.

## Operation

States and transitions:
- RUN → DRAIN when dbg_req_i=1. The request is accepted in this cycle: dbg_we_i, dbg_addr_i and dbg_wdata_i are latched. Later input changes are ignored until ack.
- DRAIN: a 4-bit counter loads DRAIN_CYCLES on entry and decrements each cycle. When it reaches 1, next state is ACCESS.
- ACCESS: performs the latched operation; next state is RESP.
  - Exception: if wb_wr_en_i=1 in this cycle, the WB write takes the port, no debug operation happens, and the state stays ACCESS.
- RESP: dbg_ack_o=1 for exactly one cycle. Next state is HALTED if dbg_hold_i=1, else RUN.
- HALTED:
  - dbg_req_i=1 → ACCESS directly, with no drain; the request is latched as in RUN.
  - Otherwise, dbg_hold_i=0 → RUN.
  - If req and hold-release arrive in the same cycle, req wins.
- A req still high in the cycle after ack is a new request.
- A req deasserted before ack does not cancel the accepted access.

Port muxing:
- Outside ACCESS: rf_wr_en_o/rf_waddr_o/rf_wdata_o pass wb_* through, and rf_rs1_raddr_o = id_rs1_raddr_i.
- ACCESS, write, no WB collision: drive rf_wr_en_o=1 with the latched addr/data. If the latched addr = 0, rf_wr_en_o stays 0 but the access still completes and acks.
- ACCESS, read: rf_rs1_raddr_o = latched addr. rf_rs1_rdata_i is registered into dbg_rdata_o at the end of the cycle. Address 0 forces 0.

Status outputs:
- halt_o = 1 in DRAIN, ACCESS, RESP and HALTED.
- halted_o = 1 in ACCESS, RESP and HALTED.
- Both are decoded from registered state, so there are no combinational paths from dbg_* inputs to them.

Reset:
- rst_i=1 forces RUN and clears the latched request and counter.
- Any access in progress is discarded without an ack.
- Output reset values: dbg_ack_o=0, dbg_rdata_o=0, halt_o=0, halted_o=0.
- rf_wr_en_o equals wb_wr_en_i; the port is not suppressed.

## Timing

- Cold request with req accepted in cycle 0:
  - DRAIN: cycles 1..DRAIN_CYCLES, halt_o=1 from cycle 1.
  - ACCESS: cycle DRAIN_CYCLES+1.
  - Ack: cycle DRAIN_CYCLES+2.
  - Latency is DRAIN_CYCLES+2 (5 at default).
- Halted request accepted in cycle 0: ACCESS in cycle 1, ack in cycle 2.
- Each WB collision in ACCESS adds one cycle; there is no upper bound.
- Debug write: the regfile is updated at the end of the ACCESS cycle, so the value is readable from the ACK cycle onward.
- Resume after RESP with hold=0: halt_o=0 in the following cycle.

## Test plan

- Cold write:
  - Stimulus: req, we=1, addr=5, wdata=0xDEADBEEF, hold=0.
  - Required: halt_o rises 1 cycle later; rf_wr_en_o=1 to x5 in cycle 4; ack in cycle 5; halt_o low in cycle 6.
- Held multi-access:
  - Stimulus: hold=1; write x7=0x1234; then read x7.
  - Required: second access has no drain and acks 2 cycles after acceptance with dbg_rdata_o=0x00001234. Dropping hold then returns to RUN with halt_o=0.
- x0 handling:
  - Stimulus: write x0=0xFFFFFFFF, then read x0.
  - Required: rf_wr_en_o never asserted for the debug write; both access acked; rdata=0.
- WB collision:
  - Stimulus: wb_wr_en_i=1 (x3=0xA5) during the first two ACCESS cycles of a debug write to x3=0x5A.
  - Required: WB writes pass through; debug write lands in the 3rd ACCESS cycle; final x3=0x5A; ack delayed by 2 cycles.
- Reset mid-drain:
  - Stimulus: rst_i=1 in DRAIN cycle 2.
  - Required: next cycle state is RUN; halt_o=0; no ack; no debug write ever issued.
- Passthrough:
  - Stimulus: in RUN, random id_rs1_raddr_i and wb_* traffic.
  - Required: rf_* equals the inputs every cycle; dbg_ack_o stays 0.
